// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath mux/ALU select codes and the bundled control-output struct.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_R_EXEC    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_I_EXEC    = 4'd10,
      ST_I_WB      = 4'd11
   } state_e;

   localparam logic [1:0] SRCA_PC     = 2'd0;
   localparam logic [1:0] SRCA_RS     = 2'd1;
   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       mem_read;
      logic       mem_write;
      logic [3:0] be;
      logic       ir_write;
      logic       mem2reg;
      logic       reg_dst;
      logic       reg_write;
      logic       ext_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_ctrl_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI};
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-output decoder: current state, opcode and effective
// memory-ready turn into the full set of datapath control signals.
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  state_e      state_i,
   input  logic [5:0]  opcode_i,
   input  logic        ready_i,
   output ctrl_t       ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_read    = 1'b1;
            ctrl_o.alu_src_a   = SRCA_PC;
            ctrl_o.alu_src_b   = SRCB_FOUR;
            ctrl_o.alu_ctrl_op = ALU_ADD;
            ctrl_o.pc_source   = PCSRC_ALU;
            // IR and PC only commit once the fetched word is actually there
            ctrl_o.ir_write    = ready_i;
            ctrl_o.pc_write    = ready_i;
         end
         ST_DECODE: begin
            ctrl_o.alu_src_a   = SRCA_PC;
            ctrl_o.alu_src_b   = SRCB_IMM_SH;
            ctrl_o.alu_ctrl_op = ALU_ADD;
            ctrl_o.ext_op      = 1'b1;
            ctrl_o.illegal     = !is_legal(opcode_i);
         end
         ST_MEM_ADDR: begin
            ctrl_o.alu_src_a   = SRCA_RS;
            ctrl_o.alu_src_b   = SRCB_IMM;
            ctrl_o.alu_ctrl_op = ALU_ADD;
            ctrl_o.ext_op      = 1'b1;
         end
         ST_MEM_READ: begin
            ctrl_o.mem_read = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem2reg    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         ST_MEM_WRITE: begin
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.instr_done = ready_i;
         end
         ST_R_EXEC: begin
            ctrl_o.alu_src_a   = SRCA_RS;
            ctrl_o.alu_src_b   = SRCB_RT;
            ctrl_o.alu_ctrl_op = ALU_FUNCT;
         end
         ST_R_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_o.alu_src_a     = SRCA_RS;
            ctrl_o.alu_src_b     = SRCB_RT;
            ctrl_o.alu_ctrl_op   = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.instr_done    = 1'b1;
         end
         ST_JUMP: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_source  = PCSRC_JUMP;
            ctrl_o.instr_done = 1'b1;
         end
         ST_I_EXEC: begin
            ctrl_o.alu_src_a = SRCA_RS;
            ctrl_o.alu_src_b = SRCB_IMM;
            if (opcode_i == OP_ORI) begin
               ctrl_o.ext_op      = 1'b0;
               ctrl_o.alu_ctrl_op = ALU_OR;
            end else begin
               ctrl_o.ext_op      = 1'b1;
               ctrl_o.alu_ctrl_op = ALU_ADD;
            end
         end
         ST_I_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ;
      endcase
      ctrl_o.be = (ctrl_o.mem_read || ctrl_o.mem_write) ? 4'hF : 4'h0;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: holds the state register,
// sequences each instruction and drives every datapath control input.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       MemRead,
   output logic       MemWrite,
   output logic [3:0] BE,
   output logic       IRWrite,
   output logic       Mem2Reg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ExtOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUCtrlOp,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   state_e state_q, state_d;
   ctrl_t  dec_ctrl, ctrl;
   logic   ready;

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
               OP_R:            state_d = ST_R_EXEC;
               OP_BEQ, OP_BNE:  state_d = ST_BRANCH;
               OP_J:            state_d = ST_JUMP;
               OP_ADDI, OP_ORI: state_d = ST_I_EXEC;
               default:         state_d = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR: begin
            if (opcode == OP_SW)      state_d = ST_MEM_WRITE;
            else if (opcode == OP_LW) state_d = ST_MEM_READ;
            else                      state_d = ST_FETCH;
         end
         ST_MEM_READ:  if (ready) state_d = ST_MEM_WB;
         ST_MEM_WRITE: if (ready) state_d = ST_FETCH;
         ST_R_EXEC:    state_d = ST_R_WB;
         ST_I_EXEC:    state_d = ST_I_WB;
         default:      state_d = ST_FETCH;
      endcase
   end

   ctrl_out_decode u_dec (
      .state_i  (state_q),
      .opcode_i (opcode),
      .ready_i  (ready),
      .ctrl_o   (dec_ctrl)
   );

   // Reset masks outputs combinationally so no strobe survives rst falling
   assign ctrl      = rst ? dec_ctrl : '0;
   assign state_dbg = rst ? state_q : 4'd0;

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign PCSource    = ctrl.pc_source;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign BE          = ctrl.be;
   assign IRWrite     = ctrl.ir_write;
   assign Mem2Reg     = ctrl.mem2reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ExtOp       = ctrl.ext_op;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUCtrlOp   = ctrl.alu_ctrl_op;
   assign instr_done  = ctrl.instr_done;
   assign illegal     = ctrl.illegal;

endmodule
